// File: rtl/alu_rs_multi_pkg.sv
// Shared types for the multi-entry ALU reservation station.
// Operand, entry and CDB structs live in the top module because their widths follow its parameters.
package alu_rs_multi_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SLL = 3'd1,
      ALU_SRA = 3'd2,
      ALU_SUB = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SRL = 3'd5,
      ALU_OR  = 3'd6,
      ALU_AND = 3'd7
   } alu_ops_e;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the reservation station plus a one-hot oldest-ready picker.
// age_q[i][j] set means entry i was allocated before entry j.
module rs_age_select #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alloc_en,
   input  logic [$clog2(DEPTH)-1:0] alloc_idx,
   input  logic [DEPTH-1:0]         busy,
   input  logic [DEPTH-1:0]         ready,
   output logic [DEPTH-1:0]         grant,
   output logic                     any
);

   logic [DEPTH-1:0] age_q [DEPTH];
   logic [DEPTH-1:0] age_d [DEPTH];

   // New entry is younger than every busy entry; its own row is cleared.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_d[i] = age_q[i];
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = '0;
         end
      end else if (alloc_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            age_d[i][alloc_idx] = busy[i];
         end
         age_d[alloc_idx] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         age_q <= age_d;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = ready[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && ready[j] && !age_q[i][j]) begin
               grant[i] = 1'b0;
            end
         end
      end
   end

   assign any = |ready;

endmodule

// File: rtl/alu_rs_multi.sv
// Parametrised ALU reservation station: CDB operand capture (with allocation bypass),
// oldest-ready issue into a shared ALU, and a one-deep result register with request/grant.
module alu_rs_multi
   import alu_rs_multi_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int NUM_CDB = 4,
   parameter int TAG_W   = 4,
   parameter int XLEN    = 32,
   parameter int OP_W    = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   input  logic [OP_W-1:0]            alloc_op,
   input  logic [TAG_W-1:0]           alloc_rob_idx,
   input  logic                       alloc_rs1_valid,
   input  logic                       alloc_rs2_valid,
   input  logic [TAG_W-1:0]           alloc_rs1_tag,
   input  logic [TAG_W-1:0]           alloc_rs2_tag,
   input  logic [XLEN-1:0]            alloc_rs1_value,
   input  logic [XLEN-1:0]            alloc_rs2_value,
   input  logic [NUM_CDB-1:0]         cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
   input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
   output logic                       res_valid,
   input  logic                       res_grant,
   output logic [TAG_W-1:0]           res_tag,
   output logic [XLEN-1:0]            res_value,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int SH_W  = $clog2(XLEN);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  value;
   } operand_t;

   typedef struct packed {
      logic             busy;
      logic [OP_W-1:0]  op;
      logic [TAG_W-1:0] rob_idx;
      operand_t         rs1;
      operand_t         rs2;
   } alu_rs_entry_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  value;
   } cdb_entry_t;

   cdb_entry_t [NUM_CDB-1:0] cdb;
   alu_rs_entry_t            entries_q [DEPTH];
   alu_rs_entry_t            entries_d [DEPTH];
   alu_rs_entry_t            alloc_entry;
   operand_t                 alloc_rs1, alloc_rs2;
   logic [DEPTH-1:0]         busy, ready, sel;
   logic                     any_ready, alloc_fire, issue_fire;
   logic [IDX_W-1:0]         free_idx;
   logic [OCC_W-1:0]         occ_q, occ_d;
   logic                     res_valid_q, res_valid_d;
   logic [TAG_W-1:0]         res_tag_q, res_tag_d;
   logic [XLEN-1:0]          res_value_q, res_value_d;
   logic [OP_W-1:0]          iss_op;
   logic [TAG_W-1:0]         iss_rob;
   logic [XLEN-1:0]          iss_a, iss_b;

   // Lowest CDB port wins when several broadcast the awaited tag; valid operands are kept.
   function automatic operand_t capture(input operand_t o, input cdb_entry_t [NUM_CDB-1:0] c);
      operand_t r;
      r = o;
      if (!o.valid) begin
         for (int j = NUM_CDB - 1; j >= 0; j--) begin
            if (c[j].valid && c[j].tag == o.tag) begin
               r.valid = 1'b1;
               r.value = c[j].value;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [XLEN-1:0] alu(input logic [OP_W-1:0] op,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      logic [SH_W-1:0] sh;
      sh = b[SH_W-1:0];
      case (alu_ops_e'(op))
         ALU_ADD: return a + b;
         ALU_SLL: return a << sh;
         ALU_SRA: return $signed(a) >>> sh;
         ALU_SUB: return a - b;
         ALU_XOR: return a ^ b;
         ALU_SRL: return a >> sh;
         ALU_OR:  return a | b;
         ALU_AND: return a & b;
         default: return a + b;
      endcase
   endfunction

   always_comb begin
      for (int j = 0; j < NUM_CDB; j++) begin
         cdb[j].valid = cdb_valid[j];
         cdb[j].tag   = cdb_tag[j*TAG_W +: TAG_W];
         cdb[j].value = cdb_value[j*XLEN +: XLEN];
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         busy[i]  = entries_q[i].busy;
         ready[i] = entries_q[i].busy && entries_q[i].rs1.valid && entries_q[i].rs2.valid;
      end
   end

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!entries_q[i].busy) free_idx = IDX_W'(i);
      end
   end

   rs_age_select #(
      .DEPTH (DEPTH)
   ) u_age (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .alloc_en  (alloc_fire),
      .alloc_idx (free_idx),
      .busy      (busy),
      .ready     (ready),
      .grant     (sel),
      .any       (any_ready)
   );

   assign alloc_ready = (occ_q != OCC_W'(DEPTH));
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign issue_fire  = any_ready && (!res_valid_q || res_grant);

   always_comb begin
      alloc_rs1.valid     = alloc_rs1_valid;
      alloc_rs1.tag       = alloc_rs1_tag;
      alloc_rs1.value     = alloc_rs1_value;
      alloc_rs2.valid     = alloc_rs2_valid;
      alloc_rs2.tag       = alloc_rs2_tag;
      alloc_rs2.value     = alloc_rs2_value;
      alloc_entry.busy    = 1'b1;
      alloc_entry.op      = alloc_op;
      alloc_entry.rob_idx = alloc_rob_idx;
      alloc_entry.rs1     = capture(alloc_rs1, cdb);
      alloc_entry.rs2     = capture(alloc_rs2, cdb);
   end

   // An issued slot is only seen as free next cycle, so it never collides with free_idx.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entries_d[i] = entries_q[i];
         if (entries_q[i].busy) begin
            entries_d[i].rs1 = capture(entries_q[i].rs1, cdb);
            entries_d[i].rs2 = capture(entries_q[i].rs2, cdb);
         end
         if (issue_fire && sel[i]) entries_d[i].busy = 1'b0;
         if (alloc_fire && free_idx == IDX_W'(i)) entries_d[i] = alloc_entry;
         if (flush) entries_d[i].busy = 1'b0;
      end
   end

   always_comb begin
      iss_op  = '0;
      iss_rob = '0;
      iss_a   = '0;
      iss_b   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel[i]) begin
            iss_op  = entries_q[i].op;
            iss_rob = entries_q[i].rob_idx;
            iss_a   = entries_q[i].rs1.value;
            iss_b   = entries_q[i].rs2.value;
         end
      end
   end

   always_comb begin
      res_valid_d = res_valid_q;
      res_tag_d   = res_tag_q;
      res_value_d = res_value_q;
      if (flush) begin
         res_valid_d = 1'b0;
      end else if (issue_fire) begin
         res_valid_d = 1'b1;
         res_tag_d   = iss_rob;
         res_value_d = alu(iss_op, iss_a, iss_b);
      end else if (res_grant) begin
         res_valid_d = 1'b0;
      end
   end

   assign occ_d = flush ? '0 : occ_q + OCC_W'(alloc_fire) - OCC_W'(issue_fire);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         occ_q       <= '0;
         res_valid_q <= 1'b0;
         res_tag_q   <= '0;
         res_value_q <= '0;
      end else begin
         entries_q   <= entries_d;
         occ_q       <= occ_d;
         res_valid_q <= res_valid_d;
         res_tag_q   <= res_tag_d;
         res_value_q <= res_value_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_tag   = res_tag_q;
   assign res_value = res_value_q;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_alu_rs_multi.sv
// Bench for alu_rs_multi: ALU vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model of the reservation station.
module tb_alu_rs_multi;

   localparam int DEPTH   = 8;
   localparam int NUM_CDB = 4;
   localparam int TAG_W   = 4;
   localparam int XLEN    = 32;
   localparam int OP_W    = 3;
   localparam int OCC_W   = $clog2(DEPTH + 1);

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     flush;
   logic                     alloc_valid;
   logic                     alloc_ready;
   logic [OP_W-1:0]          alloc_op;
   logic [TAG_W-1:0]         alloc_rob_idx;
   logic                     alloc_rs1_valid, alloc_rs2_valid;
   logic [TAG_W-1:0]         alloc_rs1_tag, alloc_rs2_tag;
   logic [XLEN-1:0]          alloc_rs1_value, alloc_rs2_value;
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*TAG_W-1:0] cdb_tag;
   logic [NUM_CDB*XLEN-1:0]  cdb_value;
   logic                     res_valid;
   logic                     res_grant;
   logic [TAG_W-1:0]         res_tag;
   logic [XLEN-1:0]          res_value;
   logic [OCC_W-1:0]         occupancy;

   always #5 clk = ~clk;

   alu_rs_multi #(
      .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .alloc_valid     (alloc_valid),
      .alloc_ready     (alloc_ready),
      .alloc_op        (alloc_op),
      .alloc_rob_idx   (alloc_rob_idx),
      .alloc_rs1_valid (alloc_rs1_valid),
      .alloc_rs2_valid (alloc_rs2_valid),
      .alloc_rs1_tag   (alloc_rs1_tag),
      .alloc_rs2_tag   (alloc_rs2_tag),
      .alloc_rs1_value (alloc_rs1_value),
      .alloc_rs2_value (alloc_rs2_value),
      .cdb_valid       (cdb_valid),
      .cdb_tag         (cdb_tag),
      .cdb_value       (cdb_value),
      .res_valid       (res_valid),
      .res_grant       (res_grant),
      .res_tag         (res_tag),
      .res_value       (res_value),
      .occupancy       (occupancy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: waiting ops kept in allocation order, oldest at the front.
   typedef struct {
      logic [2:0]  op;
      logic [3:0]  rob;
      logic        v1, v2;
      logic [3:0]  t1, t2;
      logic [31:0] x1, x2;
   } ment_t;

   ment_t       mq[$];
   logic        m_rv;
   logic [3:0]  m_rt;
   logic [31:0] m_rval;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, exp;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         3'd0:    return a + b;
         3'd1:    return a << sh;
         3'd2:    return 32'($signed(a) >>> sh);
         3'd3:    return a - b;
         3'd4:    return a ^ b;
         3'd5:    return a >> sh;
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic cdb_hit(input logic [3:0] t, output bit h, output logic [31:0] v);
      h = 0;
      v = '0;
      for (int p = 0; p < NUM_CDB; p++) begin
         if (!h && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) begin
            h = 1;
            v = cdb_value[p*XLEN +: XLEN];
         end
      end
   endtask

   task automatic model_step();
      int          iss;
      bit          do_iss, do_alloc, h;
      logic [31:0] r, v;
      ment_t       e;
      iss = -1;
      r   = '0;
      for (int k = 0; k < mq.size(); k++) begin
         if (iss < 0 && mq[k].v1 && mq[k].v2) iss = k;
      end
      do_iss   = (iss >= 0) && (!m_rv || res_grant);
      do_alloc = alloc_valid && (mq.size() < DEPTH);
      if (do_iss) r = ref_alu(mq[iss].op, mq[iss].x1, mq[iss].x2);
      for (int k = 0; k < mq.size(); k++) begin
         e = mq[k];
         if (!e.v1) begin cdb_hit(e.t1, h, v); if (h) begin e.v1 = 1; e.x1 = v; end end
         if (!e.v2) begin cdb_hit(e.t2, h, v); if (h) begin e.v2 = 1; e.x2 = v; end end
         mq[k] = e;
      end
      if (flush) begin
         mq.delete();
         m_rv = 0;
      end else begin
         if (do_iss) begin
            m_rv   = 1;
            m_rt   = mq[iss].rob;
            m_rval = r;
            mq.delete(iss);
         end else if (res_grant) begin
            m_rv = 0;
         end
         if (do_alloc) begin
            e.op  = alloc_op;         e.rob = alloc_rob_idx;
            e.v1  = alloc_rs1_valid;  e.t1  = alloc_rs1_tag;  e.x1 = alloc_rs1_value;
            e.v2  = alloc_rs2_valid;  e.t2  = alloc_rs2_tag;  e.x2 = alloc_rs2_value;
            if (!e.v1) begin cdb_hit(e.t1, h, v); if (h) begin e.v1 = 1; e.x1 = v; end end
            if (!e.v2) begin cdb_hit(e.t2, h, v); if (h) begin e.v2 = 1; e.x2 = v; end end
            mq.push_back(e);
         end
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("alloc_ready", 64'(alloc_ready), 64'(mq.size() != DEPTH));
      chk("res_valid", 64'(res_valid), 64'(m_rv));
      if (m_rv) begin
         chk("res_tag", 64'(res_tag), 64'(m_rt));
         chk("res_value", 64'(res_value), 64'(m_rval));
      end
   endtask

   task automatic clr_inputs();
      flush           = 0;
      alloc_valid     = 0;
      alloc_op        = '0;
      alloc_rob_idx   = '0;
      alloc_rs1_valid = 0;  alloc_rs2_valid = 0;
      alloc_rs1_tag   = '0; alloc_rs2_tag   = '0;
      alloc_rs1_value = '0; alloc_rs2_value = '0;
      cdb_valid       = '0;
      cdb_tag         = '0;
      cdb_value       = '0;
   endtask

   task automatic set_alloc(input logic [2:0] op, input logic [3:0] rob,
                            input logic v1, input logic [3:0] t1, input logic [31:0] x1,
                            input logic v2, input logic [3:0] t2, input logic [31:0] x2);
      alloc_valid     = 1;
      alloc_op        = op;
      alloc_rob_idx   = rob;
      alloc_rs1_valid = v1; alloc_rs1_tag = t1; alloc_rs1_value = x1;
      alloc_rs2_valid = v2; alloc_rs2_tag = t2; alloc_rs2_value = x2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0] = '{3'd0, 32'd5,          32'd7,      32'd12};
      vt[1] = '{3'd3, 32'd5,          32'd7,      32'hFFFF_FFFE};
      vt[2] = '{3'd1, 32'd1,          32'd33,     32'd2};
      vt[3] = '{3'd2, 32'h8000_0000,  32'd4,      32'hF800_0000};
      vt[4] = '{3'd5, 32'h8000_0000,  32'd4,      32'h0800_0000};
      vt[5] = '{3'd4, 32'h0000_F0F0,  32'h0FF0,   32'h0000_FF00};
      vt[6] = '{3'd6, 32'h0000_F000,  32'h000F,   32'h0000_F00F};
      vt[7] = '{3'd7, 32'h0000_FF0F,  32'h0FF0,   32'h0000_0F00};

      mq.delete();
      m_rv = 0; m_rt = '0; m_rval = '0;
      rst = 0;
      res_grant = 0;
      clr_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_occupancy", 64'(occupancy), 64'd0);
      chk("reset_res_valid", 64'(res_valid), 64'd0);
      chk("reset_res_tag", 64'(res_tag), 64'd0);
      chk("reset_res_value", 64'(res_value), 64'd0);
      chk("reset_alloc_ready", 64'(alloc_ready), 64'd1);
      #3 rst = 1;

      // ALU vectors: ready alloc, result two cycles after alloc is presented
      res_grant = 1;
      for (int i = 0; i < 8; i++) begin
         set_alloc(vt[i].op, 4'(i + 3), 1, 4'd0, vt[i].a, 1, 4'd0, vt[i].b);
         cyc();
         alloc_valid = 0;
         chk("vec_latency_res_valid", 64'(res_valid), 64'd0);
         cyc();
         chk("vec_res_valid", 64'(res_valid), 64'd1);
         chk("vec_res_value", 64'(res_value), 64'(vt[i].exp));
         chk("vec_res_tag", 64'(res_tag), 64'(i + 3));
      end
      cyc();

      // Allocation bypass from CDB port 2; port 0 carries the same tag but is not valid
      set_alloc(3'd0, 4'd7, 0, 4'd9, 32'd0, 1, 4'd0, 32'd1);
      cdb_valid = 4'b0100;
      cdb_tag[0 +: 4]   = 4'd9;  cdb_value[0 +: 32]  = 32'hDEAD;
      cdb_tag[8 +: 4]   = 4'd9;  cdb_value[64 +: 32] = 32'h10;
      cyc();
      clr_inputs();
      cyc();
      chk("bypass_res_value", 64'(res_value), 64'h11);
      chk("bypass_res_tag", 64'(res_tag), 64'd7);
      cyc();

      // Age order: A waits on tag 4, B and C ready
      set_alloc(3'd0, 4'd1, 0, 4'd4, 32'd0, 1, 4'd0, 32'd3);
      cyc();
      set_alloc(3'd0, 4'd2, 1, 4'd0, 32'd10, 1, 4'd0, 32'd20);
      cyc();
      chk("age_idle_res_valid", 64'(res_valid), 64'd0);
      set_alloc(3'd0, 4'd3, 1, 4'd0, 32'd1, 1, 4'd0, 32'd2);
      cyc();
      chk("age_first_tag", 64'(res_tag), 64'd2);
      chk("age_first_value", 64'(res_value), 64'd30);
      clr_inputs();
      cyc();
      chk("age_second_tag", 64'(res_tag), 64'd3);
      cdb_valid = 4'b0010;
      cdb_tag[4 +: 4] = 4'd4; cdb_value[32 +: 32] = 32'd100;
      cyc();
      chk("age_wake_res_valid", 64'(res_valid), 64'd0);
      clr_inputs();
      cyc();
      chk("age_last_tag", 64'(res_tag), 64'd1);
      chk("age_last_value", 64'(res_value), 64'd103);
      cyc();

      // Backpressure and full
      res_grant = 0;
      set_alloc(3'd0, 4'd5, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1);
      cyc();
      for (int k = 0; k <= DEPTH; k++) begin
         set_alloc(3'd0, 4'(k + 6), 1, 4'd0, 32'(k), 1, 4'd0, 32'(k));
         cyc();
      end
      chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
      chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
      chk("held_res_value", 64'(res_value), 64'd2);
      chk("held_res_tag", 64'(res_tag), 64'd5);
      cyc();
      chk("full_ignore_occupancy", 64'(occupancy), 64'(DEPTH));
      chk("held_res_value2", 64'(res_value), 64'd2);
      clr_inputs();
      res_grant = 1;
      cyc();
      chk("drain_alloc_ready", 64'(alloc_ready), 64'd1);
      chk("drain_first_tag", 64'(res_tag), 64'd6);
      chk("drain_first_value", 64'(res_value), 64'd0);
      for (int k = 0; k < DEPTH; k++) begin
         cyc();
      end
      chk("drain_empty", 64'(occupancy), 64'd0);

      // Flush with alloc and a pending result in the same cycle
      res_grant = 0;
      set_alloc(3'd0, 4'd1, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1);
      cyc();
      set_alloc(3'd0, 4'd2, 1, 4'd0, 32'd2, 1, 4'd0, 32'd2);
      cyc();
      flush = 1;
      set_alloc(3'd0, 4'd3, 1, 4'd0, 32'd3, 1, 4'd0, 32'd3);
      cyc();
      chk("flush_occupancy", 64'(occupancy), 64'd0);
      chk("flush_res_valid", 64'(res_valid), 64'd0);
      clr_inputs();
      cyc();
      chk("flush_no_capture_res_valid", 64'(res_valid), 64'd0);
      chk("flush_no_capture_occupancy", 64'(occupancy), 64'd0);
      chk("flush_alloc_ready", 64'(alloc_ready), 64'd1);

      // Asynchronous reset mid-operation
      set_alloc(3'd0, 4'd1, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1);
      cyc();
      for (int k = 0; k < 3; k++) begin
         set_alloc(3'd0, 4'(k + 2), 0, 4'd15, 32'd0, 1, 4'd0, 32'd1);
         cyc();
      end
      chk("pre_reset_occupancy", 64'(occupancy), 64'd3);
      clr_inputs();
      #2 rst = 0;
      #1;
      chk("async_reset_occupancy", 64'(occupancy), 64'd0);
      chk("async_reset_res_valid", 64'(res_valid), 64'd0);
      chk("async_reset_alloc_ready", 64'(alloc_ready), 64'd1);
      chk("async_reset_res_value", 64'(res_value), 64'd0);
      mq.delete();
      m_rv = 0; m_rt = '0; m_rval = '0;
      #2 rst = 1;

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         alloc_valid     = 1'($urandom_range(0, 1));
         alloc_op        = 3'($urandom_range(0, 7));
         alloc_rob_idx   = 4'($urandom);
         alloc_rs1_valid = 1'($urandom_range(0, 1));
         alloc_rs2_valid = 1'($urandom_range(0, 1));
         alloc_rs1_tag   = 4'($urandom_range(0, 7));
         alloc_rs2_tag   = 4'($urandom_range(0, 7));
         alloc_rs1_value = $urandom;
         alloc_rs2_value = $urandom;
         for (int p = 0; p < NUM_CDB; p++) begin
            cdb_valid[p]               = ($urandom_range(0, 9) < 4);
            cdb_tag[p*TAG_W +: TAG_W]  = 4'($urandom_range(0, 7));
            cdb_value[p*XLEN +: XLEN]  = $urandom;
         end
         res_grant = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 99) < 2);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_rs_multi.md
Name: alu_rs_multi

Overview:
Parametrised ALU reservation station and the successor to the fixed 4-entry ALU RS. It holds up to DEPTH decoded ALU ops and captures operands from NUM_CDB common-data-bus ports, including a bypass at allocation time. Each cycle it issues the oldest ready entry to one shared internal ALU. The result goes into a one-deep output register that drives a request/grant handshake to the CDB arbiter.

Parameters:
DEPTH, 8, number of RS entries (>=2)
NUM_CDB, 4, number of CDB broadcast ports snooped
TAG_W, 4, ROB index width
XLEN, 32, operand/result width
OP_W, 3, ALU opcode width (alu_ops encoding)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash (branch mispredict)
alloc_valid  in  1  decoder presents an op
alloc_ready  out  1  at least one free entry
alloc_op  in  OP_W  ALU opcode
alloc_rob_idx  in  TAG_W  destination ROB tag
alloc_rs1_valid / alloc_rs2_valid  in  1 each  operand already has a value
alloc_rs1_tag / alloc_rs2_tag  in  TAG_W each  producer ROB tag if not valid
alloc_rs1_value / alloc_rs2_value  in  XLEN each  operand value if valid
cdb_valid  in  NUM_CDB  per-port broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  broadcast tags
cdb_value  in  NUM_CDB*XLEN  broadcast values
res_valid  out  1  result register holds a result (CDB request)
res_grant  in  1  arbiter accepts the result this cycle
res_tag  out  TAG_W  ROB tag of result
res_value  out  XLEN  ALU result
occupancy  out  $clog2(DEPTH+1)  number of busy entries

Behaviour:
- Reset (rst low, async): all entries not busy, age matrix cleared, res_valid=0, res_tag=0, res_value=0, occupancy=0, alloc_ready=1 after release.
- Flush (sync, priority over everything except reset): in the same edge, all entries freed, res_valid=0, and any alloc or issue in that cycle is dropped. alloc_ready=1 the next cycle.
- alloc_ready = (occupancy != DEPTH), derived from registered state only.
- An entry freed by issue this cycle is reusable next cycle, never the same cycle.
- Allocation: on alloc_valid && alloc_ready, write the lowest-index free entry.
  - Per operand: if not valid and any cdb_valid[j] has cdb_tag[j] == that tag in this same cycle, store the CDB value with valid=1 (allocation bypass).
  - alloc_valid while full: ignored, with no state change.
- Wakeup: each cycle, every busy entry with an invalid operand compares against all NUM_CDB ports. On a match it latches the value and sets valid. If multiple ports match, the lowest port index wins. Valid operands are never overwritten.
- Ready: busy && rs1.valid && rs2.valid, evaluated from registered state. A newly allocated or newly woken entry becomes issuable the following cycle.
- Age: DEPTH x DEPTH age matrix. On allocate, the new entry is marked younger than all busy entries. Select = the ready entry older than every other ready entry (exactly one-hot).
- Issue condition: any ready entry && (!res_valid || res_grant).
  - On issue, the selected entry is freed.
  - On the same edge: res_value <= alu(op, rs1.value, rs2.value), res_tag <= rob_idx, res_valid <= 1.
  - Latency: issue edge to res_valid is 1 cycle. Allocation with both operands valid to res_valid is 2 cycles.
- Result handshake: res_valid && res_grant retires the result. Without a simultaneous issue, res_valid <= 0. With back-to-back issue, the new result replaces it, giving 1 result/cycle sustained.
- res_valid && !res_grant: result register and outputs held stable, and issue stalls.
- Simultaneous alloc + issue + wakeup in one cycle is legal. occupancy updates by +1, -1, or 0 accordingly.
- ALU is combinational, with the shared alu_ops encoding: add, sll, sra, sub, xor, srl, or, and. Shift amount is b[4:0], i.e. low log2(XLEN) bits.

Decomposition:
- Shared structs package:
  - alu_rs_entry_t: busy, op, rob_idx, rs1/rs2 {valid, tag, value}.
  - cdb_entry_t with a valid bit.
- rv32i_types: alu_ops.
- Sub-module rs_age_select: age matrix plus oldest-ready one-hot picker, parametrised by DEPTH.
- Existing alu module reused combinationally.

Test Plan:
- Reset mid-operation: fill 3 entries, pull rst low asynchronously -> occupancy=0, res_valid=0 immediately, alloc_ready=1.
- Ready alloc: alloc add, rs1=5, rs2=7 (both valid), rob_idx=3, res_grant=1 -> res_valid=1 two cycles after alloc with res_value=12, res_tag=3.
- Allocation bypass:
  - Step: alloc with rs1 tag=9 invalid while cdb port 2 broadcasts tag 9, value 0x10 in that cycle; rs2=1 valid, op add.
  - Expected: result 0x11.
- Age order: alloc A (waits on tag 4), then B ready, then C ready; hold grant=1 -> B issues, then C. Broadcast tag 4 -> A issues last. Ages respected among ready entries.
- Backpressure and full:
  - Step: res_grant=0, fill all DEPTH entries.
  - Expected: alloc_ready=0, and extra alloc is ignored. res_value is held stable.
  - Step: raise grant.
  - Expected: one result retires per cycle, and alloc_ready=1 the cycle after the first issue.
- Flush with alloc and pending result in same cycle -> next cycle occupancy=0, res_valid=0, and the alloc was not captured.
